// File: rtl/uart_frame_loopback.sv
// Receives one frame of UART words into RAM, then replays it to the transmitter.
// Define FRAME_REVERSE_EN to replay each frame in reverse order.
module uart_frame_loopback #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic              mode,
  input  logic [ADDR_W:0]   frame_len,
  input  logic [DATA_W-1:0] term_char,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_ready,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  output logic [2:0]        state,
  output logic [15:0]       frame_count,
  output logic              overflow
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRecv   = 3'd1;
  localparam logic [2:0] StRdAddr = 3'd2;
  localparam logic [2:0] StRdData = 3'd3;
  localparam logic [2:0] StSend   = 3'd4;

`ifdef FRAME_REVERSE_EN
  localparam bit Reverse = 1'b1;
`else
  localparam bit Reverse = 1'b0;
`endif

  localparam logic [ADDR_W:0] DepthLen = (ADDR_W + 1)'(DEPTH);

  logic [2:0]        state_q, state_d;
  logic              mode_q, mode_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [DATA_W-1:0] term_q, term_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              rx_ready_q, rx_ready_d;
  logic              tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic              overflow_q, overflow_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  logic              rx_fire;
  logic              tx_fire;
  logic [ADDR_W:0]   eff_len;
  logic [ADDR_W:0]   wr_count;
  logic              full;
  logic              is_term;
  logic              frame_end;
  logic              rd_last;

  assign rx_fire  = rx_valid & rx_ready_q;
  assign tx_fire  = tx_valid_q & tx_ready;
  assign eff_len  = (frame_len == '0 || frame_len > DepthLen) ? DepthLen : frame_len;
  // Words stored once the current transfer lands.
  assign wr_count = {1'b0, wr_ptr_q} + (ADDR_W + 1)'(1);
  assign full     = (wr_count == DepthLen);
  assign is_term  = (rx_data == term_q);
  assign frame_end = mode_q ? (is_term || full) : (wr_count == len_q);
  assign rd_last  = Reverse ? (rd_ptr_q == '0) : (rd_ptr_q == last_q);

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    len_d         = len_q;
    term_d        = term_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    last_d        = last_q;
    rx_ready_d    = rx_ready_q;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    frame_count_d = frame_count_q;
    overflow_d    = overflow_q;

    case (state_q)
      StIdle: begin
        if (enable) begin
          mode_d     = mode;
          len_d      = eff_len;
          term_d     = term_char;
          wr_ptr_d   = '0;
          rx_ready_d = 1'b1;
          state_d    = StRecv;
        end
      end
      StRecv: begin
        if (rx_fire) begin
          if (frame_end) begin
            rx_ready_d = 1'b0;
            last_d     = wr_ptr_q;
            rd_ptr_d   = Reverse ? wr_ptr_q : '0;
            wr_ptr_d   = '0;
            if (mode_q && full && !is_term) overflow_d = 1'b1;
            state_d    = StRdAddr;
          end else begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          end
        end
      end
      StRdAddr: state_d = StRdData;
      StRdData: begin
        tx_data_d  = rdata_q;
        tx_valid_d = 1'b1;
        state_d    = StSend;
      end
      StSend: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          if (rd_last) begin
            frame_count_d = frame_count_q + 16'd1;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            // Back-to-back frames pick up fresh configuration at restart.
            if (enable) begin
              mode_d     = mode;
              len_d      = eff_len;
              term_d     = term_char;
              rx_ready_d = 1'b1;
              state_d    = StRecv;
            end else begin
              state_d = StIdle;
            end
          end else begin
            rd_ptr_d = Reverse ? (rd_ptr_q - ADDR_W'(1)) : (rd_ptr_q + ADDR_W'(1));
            state_d  = StRdAddr;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= StIdle;
      mode_q        <= 1'b0;
      len_q         <= '0;
      term_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      last_q        <= '0;
      rx_ready_q    <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      frame_count_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      len_q         <= len_d;
      term_q        <= term_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      last_q        <= last_d;
      rx_ready_q    <= rx_ready_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      frame_count_q <= frame_count_d;
      overflow_q    <= overflow_d;
    end
  end

  // Frame buffer: no reset, one-cycle synchronous read.
  always_ff @(posedge clk) begin
    if (rx_fire) mem[wr_ptr_q] <= rx_data;
    rdata_q <= mem[rd_ptr_q];
  end

  assign rx_ready    = rx_ready_q;
  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign state       = state_q;
  assign frame_count = frame_count_q;
  assign overflow    = overflow_q;

endmodule

// File: doc/uart_frame_loopback.md
Name: uart_frame_loopback

Overview:
- Parametrised successor to the fixed 256-byte UART receive-then-echo loop.
- Buffers one frame of words from a UART receiver handshake into on-chip RAM, then replays the frame to a UART transmitter handshake.
- Frame end is selected at run time: fixed length or terminator word.
- Sits between the `uart` rx/tx sides and board I/O; also exposes state, frame count and overflow for LEDs/debug.

Parameters:
- DATA_W, 8, width of one UART word.
- DEPTH, 256, buffer depth in words; any value ≥ 2.
- ADDR_W, $clog2(DEPTH), buffer address width; derived, not overridden.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- enable  in  1  start/continue frame processing.
- mode  in  1  0 = fixed-length frame, 1 = terminator-delimited frame.
- frame_len  in  ADDR_W+1  fixed-mode length; 0 or >DEPTH means DEPTH.
- term_char  in  DATA_W  terminator word for mode 1.
- rx_valid  in  1  receiver word available.
- rx_data  in  DATA_W  receiver word.
- rx_ready  out  1  block accepts receiver word.
- tx_valid  out  1  word offered to transmitter.
- tx_data  out  DATA_W  word to transmit.
- tx_ready  in  1  transmitter accepts word.
- state  out  3  FSM state code.
- frame_count  out  16  completed frames; wraps at 16'hFFFF→0.
- overflow  out  1  sticky; set when a terminator frame fills DEPTH without a terminator.

Behaviour:
- Reset (rstn=0, asynchronous):
  - rx_ready=0, tx_valid=0, tx_data=0, state=IDLE, frame_count=0, overflow=0.
  - Write and read pointers are cleared to 0.
  - RAM contents are not cleared.
  - Reset mid-frame discards the frame.
- Handshakes:
  - A transfer occurs only in a cycle where valid && ready.
  - tx_data and tx_valid hold stable until tx_ready.
  - rx_data is ignored while rx_ready=0.
- State codes: IDLE=0, RECV=1, RD_ADDR=2, RD_DATA=3, SEND=4.
- IDLE:
  - When enable=1, capture mode and the effective length (clamped as above).
  - Next state RECV; rx_ready=1 in the same transition.
- RECV:
  - Each rx transfer writes mem[wr_ptr] and increments wr_ptr.
  - Fixed mode: frame ends on the transfer that makes count == effective length.
  - Terminator mode: frame ends on the transfer whose word == term_char; the terminator is stored and echoed.
  - Terminator mode, DEPTH words received with no terminator: frame ends, overflow=1.
  - On frame end: rx_ready=0 from the next cycle, rd_ptr=0, next state RD_ADDR.
  - mode, frame_len and term_char changes during a frame are ignored; they are resampled only in IDLE or at frame restart.
- RD_ADDR: RAM address = rd_ptr (1-cycle synchronous read); next state RD_DATA.
- RD_DATA: register RAM output into tx_data, set tx_valid=1; next state SEND.
- SEND, on tx transfer:
  - tx_valid=0.
  - If this was the last stored word: frame_count++, pointers reset. If enable=1, go to RECV with rx_ready=1; otherwise go to IDLE.
  - If not the last word: rd_ptr++, go to RD_ADDR.
- Latency:
  - Last rx transfer at cycle N → first tx_valid=1 at cycle N+3.
  - tx transfer at cycle M → next tx_valid=1 at M+3.
- Dropping enable mid-frame has no effect until the current echo completes.
- No simultaneous receive and transmit: rx_ready and tx_valid are never both 1.

Optional Feature:
- FRAME_REVERSE_EN defined:
  - The frame is replayed in reverse order: rd_ptr starts at length−1 and decrements; the last word sent is index 0.
  - In terminator mode the terminator is sent first.
- FRAME_REVERSE_EN undefined: in-order replay as above.

Test Plan:
- Reset/idle: rstn=0, then release with enable=0 → all outputs at reset values; state=0 for 20 cycles; rx words are not accepted.
- Fixed mode: enable=1, mode=0, frame_len=4, rx 0x11,0x22,0x33,0x44 → tx 0x11,0x22,0x33,0x44; first tx_valid 3 cycles after the last rx; frame_count=1; state returns to 1.
- Terminator mode: mode=1, term_char=0x0D, rx 0x41,0x42,0x0D → tx 0x41,0x42,0x0D; overflow=0.
- Overflow, DEPTH=8: mode=1, 8 words, none equal term_char → 8 words echoed, overflow=1 and still 1 after the next good frame.
- Backpressure/length clamp: frame_len=0 with DEPTH=8 and tx_ready held low 10 cycles per word → exactly 8 words echoed; tx_data stable while stalled; rx_ready=0 throughout the echo.
- Async reset mid-SEND: after 2 of 4 words sent, assert rstn=0 → tx_valid=0 immediately; frame_count unchanged from its pre-frame value of 0; a fresh frame works after release. With FRAME_REVERSE_EN, the frame 0x11..0x44 echoes as 0x44,0x33,0x22,0x11.
